rtc_bus_responder: RTL and testbench

- Device-side responder for the 8-bit multiplexed address/data parallel bus that the FPGA-side I/O block drives.
- Decodes the cs_n/rd_n/wr_n/a_d strobes and latches the address on address write cycles.
- Stores data-cycle writes into a register file and drives the bus on data-cycle reads.
- Used as the RTC-side endpoint in system simulation and as a synthesizable loopback target on-board; an independent local port lets a timebase update registers.

---
 rtl/rtc_bus_responder.sv | 139 +++++++++++++
 tb/tb_rtc_bus_responder.sv | 232 +++++++++++++++++++++++
 2 files changed

// File: rtl/rtc_bus_responder.sv
// Device-side endpoint for the 8-bit multiplexed address/data bus: synchronizes the
// strobes, latches addresses, and serves data cycles from a small register file.
module rtc_bus_responder #(
  parameter int DATA_W   = 8,
  parameter int NUM_REGS = 16
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              cs_n,
  input  logic              rd_n,
  input  logic              wr_n,
  input  logic              a_d,
  inout  wire  [DATA_W-1:0] io_port,
  input  logic              loc_we,
  input  logic [7:0]        loc_addr,
  input  logic [DATA_W-1:0] loc_wdata,
  output logic [7:0]        cur_addr,
  output logic              wr_pulse,
  output logic              proto_err
);
  localparam int SYNC_STAGES = 2;
  localparam int IDX_W       = $clog2(NUM_REGS);
  localparam logic [8:0] NREGS = 9'(NUM_REGS);

  typedef struct packed {
    logic cs;
    logic rd;
    logic wr;
    logic ad;
  } strb_t;

  typedef enum logic [1:0] {IDLE, WR_ACT, RD_ACT, ERR_WAIT} state_t;

  localparam strb_t STRB_RST = '{cs: 1'b1, rd: 1'b1, wr: 1'b1, ad: 1'b0};

  strb_t                   sync1, strb;
  logic [SYNC_STAGES-1:0]  vld_pipe;
  state_t                  state;
  logic                    armed;
  logic                    oe;
  logic [DATA_W-1:0]       cap, rbuf;
  logic [DATA_W-1:0]       regs [NUM_REGS];
  logic                    cur_mapped, loc_mapped, strb_idle;
  logic [IDX_W-1:0]        cur_idx, loc_idx;

  assign cur_mapped = ({1'b0, cur_addr} < NREGS);
  assign loc_mapped = ({1'b0, loc_addr} < NREGS);
  assign cur_idx    = cur_addr[IDX_W-1:0];
  assign loc_idx    = loc_addr[IDX_W-1:0];
  assign strb_idle  = strb.cs | (strb.rd & strb.wr);

  assign io_port = oe ? rbuf : 'z;

  // vld_pipe marks when the synchronizer holds real samples rather than reset values,
  // so a strobe held low across reset release is not mistaken for a fresh edge.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      sync1    <= STRB_RST;
      strb     <= STRB_RST;
      vld_pipe <= '0;
    end else begin
      sync1    <= '{cs: cs_n, rd: rd_n, wr: wr_n, ad: a_d};
      strb     <= sync1;
      vld_pipe <= {vld_pipe[SYNC_STAGES-2:0], 1'b1};
    end
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state     <= IDLE;
      armed     <= 1'b0;
      oe        <= 1'b0;
      cap       <= '0;
      rbuf      <= '0;
      cur_addr  <= '0;
      wr_pulse  <= 1'b0;
      proto_err <= 1'b0;
      for (int i = 0; i < NUM_REGS; i++) regs[i] <= '0;
    end else begin
      wr_pulse <= 1'b0;
      // Local write first so a same-cycle bus commit to the same index overrides it.
      if (loc_we && loc_mapped) regs[loc_idx] <= loc_wdata;
      case (state)
        IDLE: begin
          oe <= 1'b0;
          if (!armed) begin
            armed <= vld_pipe[SYNC_STAGES-1] & strb_idle;
          end else if (!strb.cs) begin
            if (!strb.rd && !strb.wr) begin
              state     <= ERR_WAIT;
              proto_err <= 1'b1;
            end else if (!strb.wr) begin
              state <= WR_ACT;
            end else if (!strb.rd) begin
              state <= RD_ACT;
              rbuf  <= cur_mapped ? regs[cur_idx] : '0;
              oe    <= strb.ad;
            end
          end
        end
        WR_ACT: begin
          cap <= io_port;
          if (!strb.rd) begin
            state     <= ERR_WAIT;
            proto_err <= 1'b1;
          end else if (strb.wr || strb.cs) begin
            state <= IDLE;
            if (!strb.ad) begin
              cur_addr <= 8'(cap);
            end else if (cur_mapped) begin
              regs[cur_idx] <= cap;
              wr_pulse      <= 1'b1;
            end
          end
        end
        RD_ACT: begin
          if (!strb.wr) begin
            state     <= ERR_WAIT;
            proto_err <= 1'b1;
            oe        <= 1'b0;
          end else if (strb.rd || strb.cs) begin
            state <= IDLE;
            oe    <= 1'b0;
          end else begin
            oe <= strb.ad;
          end
        end
        ERR_WAIT: begin
          oe <= 1'b0;
          if (strb_idle) state <= IDLE;
        end
        default: begin
          state <= IDLE;
          oe    <= 1'b0;
        end
      endcase
    end
  end
endmodule

// File: tb/tb_rtc_bus_responder.sv
// Bench for rtc_bus_responder: directed vector table, multi-cycle corner sequences and a
// randomized run against a register-array model; the bus is pulled up so Z reads as 0xFF.
`timescale 1ns/1ps
module tb_rtc_bus_responder;
  localparam int         NUM_REGS = 16;
  localparam logic [7:0] NREG8    = 8'd16;
  localparam logic [7:0] ZV       = 8'hFF;

  logic       clk = 1'b0, reset_n = 1'b0;
  logic       cs_n = 1'b1, rd_n = 1'b1, wr_n = 1'b1, a_d = 1'b0;
  logic       loc_we = 1'b0;
  logic [7:0] loc_addr = '0, loc_wdata = '0;
  logic       tb_oe = 1'b0;
  logic [7:0] tb_data = '0;
  wire  [7:0] io_port;
  logic [7:0] cur_addr;
  logic       wr_pulse, proto_err;

  assign io_port = tb_oe ? tb_data : 8'hzz;
  for (genvar g = 0; g < 8; g++) begin : g_pu
    pullup pu (io_port[g]);
  end

  rtc_bus_responder #(.DATA_W(8), .NUM_REGS(NUM_REGS)) dut (
    .clk(clk), .reset_n(reset_n), .cs_n(cs_n), .rd_n(rd_n), .wr_n(wr_n), .a_d(a_d),
    .io_port(io_port), .loc_we(loc_we), .loc_addr(loc_addr), .loc_wdata(loc_wdata),
    .cur_addr(cur_addr), .wr_pulse(wr_pulse), .proto_err(proto_err)
  );

  always #5 clk = ~clk;

  int checks = 0, errors = 0, pulse_cnt = 0;
  always @(negedge clk) if (wr_pulse) pulse_cnt <= pulse_cnt + 1;

  // Reference model: what the register file and address latch should hold.
  logic [7:0] m_regs [NUM_REGS];
  logic [7:0] m_cur;

  typedef struct {
    logic       is_rd;
    logic       ad;
    logic [7:0] data;
    logic [7:0] exp;   // cur_addr after a write, data returned by a read
  } vec_t;
  vec_t tbl [16];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic mdl_reset();
    for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 8'h00;
    m_cur = 8'h00;
  endtask

  function automatic logic [7:0] mdl_read();
    return (m_cur < NREG8) ? m_regs[m_cur[3:0]] : 8'h00;
  endfunction

  task automatic loc_write(input logic [7:0] a, input logic [7:0] d);
    @(negedge clk); loc_we = 1'b1; loc_addr = a; loc_wdata = d;
    @(negedge clk); loc_we = 1'b0;
    if (a < NREG8) m_regs[a[3:0]] = d;
  endtask

  // Bus write; optionally fires a local write on exactly the commit cycle.
  task automatic bus_write(input logic ad, input logic [7:0] d, input logic do_loc,
                           input logic [7:0] la, input logic [7:0] ld);
    logic exp_pulse;
    exp_pulse = ad && (m_cur < NREG8);
    @(negedge clk); tb_data = d; tb_oe = 1'b1; a_d = ad; cs_n = 1'b0;
    @(negedge clk); wr_n = 1'b0;
    repeat (5) @(negedge clk);
    wr_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("wr_pulse_early", wr_pulse, 1'b0);
    @(negedge clk);
    if (do_loc) begin loc_we = 1'b1; loc_addr = la; loc_wdata = ld; end
    @(posedge clk); #1;
    chk("wr_pulse", wr_pulse, exp_pulse);
    @(negedge clk); loc_we = 1'b0;
    @(posedge clk); #1;
    chk("wr_pulse_width", wr_pulse, 1'b0);
    @(negedge clk); cs_n = 1'b1; tb_oe = 1'b0;
    repeat (3) @(negedge clk);
    if (do_loc && la < NREG8) m_regs[la[3:0]] = ld;
    if (!ad) m_cur = d;
    else if (m_cur < NREG8) m_regs[m_cur[3:0]] = d;
    chk("cur_addr", cur_addr, m_cur);
  endtask

  task automatic bus_read(input logic ad, input logic [7:0] exp);
    logic [7:0] want;
    want = ad ? exp : ZV;
    @(negedge clk); tb_oe = 1'b0; a_d = ad; cs_n = 1'b0;
    @(negedge clk); rd_n = 1'b0;
    @(posedge clk); @(posedge clk); #1;
    chk("rd_before_drive", io_port, ZV);
    @(posedge clk); #1;
    chk("rd_data", io_port, want);
    repeat (3) @(posedge clk); #1;
    chk("rd_hold", io_port, want);
    @(negedge clk); rd_n = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    chk("rd_before_release", io_port, want);
    @(posedge clk); #1;
    chk("rd_release", io_port, ZV);
    @(negedge clk); cs_n = 1'b1;
    repeat (3) @(negedge clk);
  endtask

  initial begin
    int         op, saved;
    logic [7:0] a, d;

    tbl[0]  = '{1'b0, 1'b0, 8'h03, 8'h03};
    tbl[1]  = '{1'b0, 1'b1, 8'h5A, 8'h03};
    tbl[2]  = '{1'b1, 1'b1, 8'h00, 8'h5A};
    tbl[3]  = '{1'b1, 1'b0, 8'h00, 8'h00};
    tbl[4]  = '{1'b0, 1'b0, 8'h20, 8'h20};
    tbl[5]  = '{1'b0, 1'b1, 8'hFF, 8'h20};
    tbl[6]  = '{1'b1, 1'b1, 8'h00, 8'h00};
    tbl[7]  = '{1'b0, 1'b0, 8'h0F, 8'h0F};
    tbl[8]  = '{1'b0, 1'b1, 8'h77, 8'h0F};
    tbl[9]  = '{1'b1, 1'b1, 8'h00, 8'h77};
    tbl[10] = '{1'b0, 1'b0, 8'h10, 8'h10};
    tbl[11] = '{1'b0, 1'b1, 8'h12, 8'h10};
    tbl[12] = '{1'b0, 1'b0, 8'h00, 8'h00};
    tbl[13] = '{1'b1, 1'b1, 8'h00, 8'h00};
    tbl[14] = '{1'b0, 1'b0, 8'h03, 8'h03};
    tbl[15] = '{1'b1, 1'b1, 8'h00, 8'h5A};

    mdl_reset();
    repeat (3) @(negedge clk);
    chk("reset_cur_addr", cur_addr, 8'h00);
    chk("reset_wr_pulse", wr_pulse, 1'b0);
    chk("reset_proto_err", proto_err, 1'b0);
    chk("reset_bus_z", io_port, ZV);
    reset_n = 1'b1;
    repeat (4) @(negedge clk);

    for (int i = 0; i < 16; i++) begin
      if (tbl[i].is_rd) bus_read(tbl[i].ad, tbl[i].exp);
      else begin
        bus_write(tbl[i].ad, tbl[i].data, 1'b0, 8'h00, 8'h00);
        chk("tbl_cur_addr", cur_addr, tbl[i].exp);
      end
    end

    // Same-cycle local and bus writes: same register -> bus wins; different -> both land.
    bus_write(1'b0, 8'h05, 1'b0, 8'h00, 8'h00);
    bus_write(1'b1, 8'h22, 1'b1, 8'h05, 8'h11);
    bus_read(1'b1, 8'h22);
    bus_write(1'b1, 8'h33, 1'b1, 8'h06, 8'h11);
    bus_read(1'b1, 8'h33);
    loc_write(8'h15, 8'h44);
    bus_read(1'b1, 8'h33);
    bus_write(1'b0, 8'h06, 1'b0, 8'h00, 8'h00);
    bus_read(1'b1, 8'h11);

    for (int n = 0; n < 60; n++) begin
      op = int'($urandom_range(0, 3));
      a  = 8'($urandom_range(0, 23));
      d  = 8'($urandom_range(0, 254));
      case (op)
        0: bus_write(1'b0, a, 1'b0, 8'h00, 8'h00);
        1: bus_write(1'b1, d, 1'($urandom_range(0, 1)), 8'($urandom_range(0, 23)),
                     8'($urandom_range(0, 254)));
        2: bus_read(1'b1, mdl_read());
        default: loc_write(a, d);
      endcase
    end
    chk("rand_proto_err", proto_err, 1'b0);

    // Both strobes low together: flag, keep bus Z, commit nothing.
    bus_write(1'b0, 8'h03, 1'b0, 8'h00, 8'h00);
    saved = pulse_cnt;
    @(negedge clk); tb_data = 8'h99; tb_oe = 1'b0; cs_n = 1'b0; a_d = 1'b1;
    @(negedge clk); rd_n = 1'b0; wr_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("perr_set", proto_err, 1'b1);
    chk("perr_bus_z", io_port, ZV);
    repeat (3) @(posedge clk); #1;
    chk("perr_bus_z_hold", io_port, ZV);
    @(negedge clk); rd_n = 1'b1; wr_n = 1'b1;
    repeat (5) @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    chk("perr_sticky", proto_err, 1'b1);
    chk("perr_no_commit", pulse_cnt, saved);
    chk("perr_cur_addr", cur_addr, m_cur);
    bus_read(1'b1, mdl_read());
    bus_write(1'b1, 8'h5A, 1'b0, 8'h00, 8'h00);
    bus_read(1'b1, 8'h5A);
    chk("perr_still_set", proto_err, 1'b1);

    // Reset while the bus is being driven, then a read held low across reset release.
    @(negedge clk); cs_n = 1'b0; a_d = 1'b1;
    @(negedge clk); rd_n = 1'b0;
    repeat (4) @(posedge clk); #1;
    chk("rst_pre_drive", io_port, 8'h5A);
    @(negedge clk); reset_n = 1'b0;
    @(posedge clk); #1;
    chk("rst_bus_z", io_port, ZV);
    chk("rst_cur_addr", cur_addr, 8'h00);
    chk("rst_proto_err", proto_err, 1'b0);
    @(negedge clk); reset_n = 1'b1;
    mdl_reset();
    for (int k = 0; k < 8; k++) begin
      @(posedge clk); #1;
      chk("rst_no_drive", io_port, ZV);
    end
    @(negedge clk); rd_n = 1'b1;
    repeat (4) @(negedge clk);
    rd_n = 1'b0;
    repeat (3) @(posedge clk); #1;
    chk("rst_redrive_cleared", io_port, 8'h00);
    @(negedge clk); rd_n = 1'b1;
    repeat (4) @(negedge clk);
    cs_n = 1'b1;
    repeat (4) @(negedge clk);
    bus_write(1'b0, 8'h05, 1'b0, 8'h00, 8'h00);
    bus_read(1'b1, 8'h00);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
